// File: rtl/morse_receiver_if.sv
// Morse receiver port bundle: serial line in, decoded letter and status out.
// master = line driver / display consumer side, slave = the receiver itself.
interface morse_receiver_if;
  logic        serial_in;
  logic [12:0] pattern;
  logic [2:0]  letter_idx;
  logic        match;
  logic        valid;
  logic        overflow;
  logic        busy;

  modport master (
    output serial_in,
    input  pattern, letter_idx, match, valid, overflow, busy
  );

  modport slave (
    input  serial_in,
    output pattern, letter_idx, match, valid, overflow, busy
  );
endinterface

// File: rtl/morse_receiver.sv
// Morse receiver: mid-bit sampling of the serial line, 13-bit pattern capture, letter table match.
// Optional MORSE_RX_SYNC_EN adds a 2-flop input synchronizer for asynchronous sources.
module morse_receiver #(
  parameter int TICK_COUNT = 25000000,
  parameter int GAP_LEN    = 3
) (
  input  logic             clock,
  input  logic             reset,
  morse_receiver_if.slave  bus
);

  localparam int              ZR_W     = $clog2(GAP_LEN + 1);
  localparam logic [24:0]     DIV_HALF = 25'(TICK_COUNT / 2 - 1);
  localparam logic [24:0]     DIV_FULL = 25'(TICK_COUNT - 1);
  localparam logic [ZR_W-1:0] ZR_LAST  = ZR_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [24:0]     div;
  logic [12:0]     shift_buf;
  logic [3:0]      bit_cnt;
  logic [ZR_W-1:0] zero_run;
  logic            line, line_prev;
  logic [12:0]     pattern_r;
  logic [2:0]      idx_r;
  logic            match_r, valid_r, overflow_r;
  logic            rise, strobe, exhausted;
  logic [3:0]      wr_idx;

`ifdef MORSE_RX_SYNC_EN
  logic sync_p0, sync_p1;
  // input synchronizer stage boundary
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.serial_in;
      sync_p1 <= sync_p0;
    end
  end
  assign line = sync_p1;
`else
  assign line = bus.serial_in;
`endif

  assign rise      = line & ~line_prev;
  assign strobe    = ((state == RECV) || (state == DRAIN)) && (div == 25'd0);
  assign exhausted = (bit_cnt == 4'd13);
  assign wr_idx    = 4'd12 - bit_cnt;

  function automatic logic [3:0] lookup(input logic [12:0] p);
    case (p)
      13'b1010000000000: lookup = 4'b1000;
      13'b1011101110111: lookup = 4'b1001;
      13'b1110101110000: lookup = 4'b1010;
      13'b1011101010000: lookup = 4'b1011;
      13'b1110111000000: lookup = 4'b1100;
      13'b1110100000000: lookup = 4'b1101;
      13'b1110111011100: lookup = 4'b1110;
      13'b1011101110100: lookup = 4'b1111;
      default:           lookup = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rise) state_nxt = RECV;
      RECV: begin
        if (strobe) begin
          if (line && exhausted)                  state_nxt = DRAIN;
          else if (!line && (zero_run == ZR_LAST)) state_nxt = DONE;
        end
      end
      DONE:  state_nxt = IDLE;
      DRAIN: if (strobe && !line && (zero_run == ZR_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Terminating zeros are never written as ones, so the buffer is already the padded pattern.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div        <= '0;
      shift_buf  <= '0;
      bit_cnt    <= '0;
      zero_run   <= '0;
      line_prev  <= 1'b0;
      pattern_r  <= '0;
      idx_r      <= '0;
      match_r    <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      line_prev <= line;
      valid_r   <= 1'b0;
      case (state)
        IDLE: begin
          div <= '0;
          if (rise) begin
            div       <= DIV_HALF;
            shift_buf <= '0;
            bit_cnt   <= '0;
            zero_run  <= '0;
          end
        end
        RECV, DRAIN: begin
          div <= strobe ? DIV_FULL : div - 25'd1;
          if (strobe) begin
            zero_run <= line ? '0 : zero_run + ZR_W'(1);
            if ((state == RECV) && !exhausted) begin
              if (line) shift_buf[wr_idx] <= 1'b1;
              bit_cnt <= bit_cnt + 4'd1;
            end
            if ((state == RECV) && line && exhausted) overflow_r <= 1'b1;
            if (state_nxt == DONE) begin
              pattern_r          <= shift_buf;
              {match_r, idx_r}   <= lookup(shift_buf);
              valid_r            <= 1'b1;
              overflow_r         <= 1'b0;
            end
          end
        end
        default: div <= '0;
      endcase
    end
  end

  assign bus.pattern    = pattern_r;
  assign bus.letter_idx = idx_r;
  assign bus.match      = match_r;
  assign bus.valid      = valid_r;
  assign bus.overflow   = overflow_r;
  assign bus.busy       = (state != IDLE);

endmodule
